peripheral_bus: RTL and testbench
=================================

# peripheral_bus

Memory-mapped peripheral responder sitting on the CPU data bus beside the data memory, selected by addresses in 0x4000_0000–0x4000_001F. Answers CPU loads combinationally and captures stores on the clock edge. Provides a reloadable interval timer with interrupt request, LED and 7-segment output registers, a switch input port and an 8N1 UART transmitter. The timer interrupt feeds the CPU `IRQ` input.

## Interface
- `CLK_DIV`, 5208: clock cycles per UART bit; the default gives 9600 baud at 50 MHz. Minimum 2.
- `clk` input 1: single system clock, rising-edge.
- `reset` input 1: asynchronous, active-high.
- `rd` input 1: CPU load strobe.
- `wr` input 1: CPU store strobe.
- `addr` input 32: byte address; bits [1:0] are ignored.
- `wdata` input 32: store data.
- `rdata` output 32: load data, combinational.
- `switch` input 8: board switches.
- `led` output 8: LED register.
- `digi` output 12: 7-segment register.
- `irqout` output 1: timer interrupt request.
- `uart_txd` output 1: serial line, idle high.

## Operation
- Register map:
  - 0x00 `TH`: reload value.
  - 0x04 `TL`: counter.
  - 0x08 `TCON`[2:0]: bit 0 = enable, bit 1 = interrupt enable, bit 2 = overflow status.
  - 0x0C `LED`[7:0].
  - 0x10 `SWITCH`[7:0]: read-only.
  - 0x14 `DIGI`[11:0].
  - 0x18 `UART_TXD`[7:0]: write-only; reads 0.
  - 0x1C `UART_CON`: bit 0 = tx done (sticky), bit 1 = busy (read-only).
- Unmapped addresses read 0 and ignore writes.
- `rdata` = 0 whenever `rd`=0. Unused upper bits read 0.
- Timer, when `TCON[0]`=1, evaluated every clock:
  - `TL`=0xFFFF_FFFF: `TL`←`TH`, and `TCON[2]`←1 if `TCON[1]`=1.
  - Otherwise `TL`←`TL`+1, wrapping modulo 2^32.
- `irqout` = `TCON[1]` & `TCON[2]`. Software clears the interrupt by writing `TCON` with bit 2 = 0.
- UART accepts a frame when `UART_TXD` is written while not busy:
  - Writes while busy are dropped.
  - Frame order: start bit (0), data bits 0–7 LSB first, stop bit (1). Each bit lasts `CLK_DIV` cycles.
  - Any write to `UART_CON` clears the done bit.
- Transmitter FSM: IDLE → START → DATA (bit index 0..7) → STOP → IDLE.
  - Bit counter and divider counter both reload on each state entry.

## Timing
- Reset values: `TH`, `TL`, `TCON`, `LED`, `DIGI`, done flag all 0; FSM in IDLE; `uart_txd`=1; `irqout`=0.
- Reads have zero latency.
- A store at edge N is visible to a load in cycle N+1.
- Timer collisions at the same edge:
  - CPU write to `TL` wins over the increment or reload.
  - CPU write to `TCON` sets bits [1:0] from `wdata`.
  - Bit 2 becomes `wdata[2]` OR the overflow set, so a set never lost.
- UART timing for a write accepted at edge N:
  - Busy=1 and `uart_txd`=0 from cycle N+1.
  - Data bit k drives cycles N+1+(k+1)·`CLK_DIV` through N+(k+2)·`CLK_DIV`.
  - Busy=0 and done=1 from cycle N+1+10·`CLK_DIV`.
  - A new write in that same cycle is accepted.
- Done-clear write colliding with done-set: the set wins.
- Reset asserted mid-frame aborts the frame immediately; `uart_txd` goes to 1.

## Configuration
- Macro: `PERIPH_UART_EN`.
- Defined: UART transmitter present as specified.
- Undefined:
  - No transmitter logic; `uart_txd` is tied to 1.
  - 0x18 and 0x1C read 0 and ignore writes.
  - `CLK_DIV` is unused.

## Structure
- Package `periph_pkg`:
  - Register offset constants.
  - `TCON` bit indices.
  - UART FSM state encoding.
  - Address-window base 0x4000_0000.
- Sub-module `uart_tx` (present under `PERIPH_UART_EN` only).
  - Inputs: `clk`, `reset`, `start`, `data[7:0]`.
  - Outputs: `txd`, `busy`, `done_pulse`.
- The sticky done flag lives in the parent.

## Test plan
- **Reset/readback:** reset, write `LED`=0xA5 and `DIGI`=0x3F7, then read them back → `led`=0xA5, `digi`=0x3F7, `TCON` reads 0; with `switch`=0x5C, `SWITCH` reads 0x5C.
- **Timer reload and IRQ:** `TH`=0xFFFF_FFFC, `TL`=0xFFFF_FFFC, `TCON`=3 → `TL` reads 0xFFFF_FFFC again and `irqout`=1 four cycles after the `TCON` write. Writing `TCON`=3 then drops `irqout` the next cycle.
- **Collision:** write `TCON`=3 on the overflow edge → bit 2 stays 1. Write `TL`=0x10 while counting → the next read shows 0x11.
- **UART frame:** `CLK_DIV`=4, write 0x55 → `uart_txd` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. Busy is 1 for 40 cycles, then `UART_CON` reads 1.
- **UART busy/done:** a second write mid-frame is ignored (line unchanged). Writing `UART_CON` makes it read 0.
- **Reset and macro:** reset mid-frame → `uart_txd`=1 the same cycle. With `PERIPH_UART_EN` undefined, writing 0x18 keeps `uart_txd`=1 and 0x1C reads 0.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// periph_pkg: register map, TCON bit positions, UART FSM encoding and address window
package periph_pkg;
    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
    localparam logic [2:0] REG_TH       = 3'd0;
    localparam logic [2:0] REG_TL       = 3'd1;
    localparam logic [2:0] REG_TCON     = 3'd2;
    localparam logic [2:0] REG_LED      = 3'd3;
    localparam logic [2:0] REG_SWITCH   = 3'd4;
    localparam logic [2:0] REG_DIGI     = 3'd5;
    localparam logic [2:0] REG_UART_TXD = 3'd6;
    localparam logic [2:0] REG_UART_CON = 3'd7;
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_OV = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;
endpackage

// File: rtl/peripheral_bus_if.sv
// peripheral_bus_if: CPU data-bus load/store signals seen by the peripheral responder
interface peripheral_bus_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output rd, wr, addr, wdata, input rdata);
    modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/peripheral_bus_uart_tx.sv
// uart_tx: 8N1 serial transmitter, CLK_DIV clocks per bit
module uart_tx import periph_pkg::*; #(
    parameter int CLK_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done_pulse
);
    localparam int DW = $clog2(CLK_DIV);
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          last;
    always_comb begin
        last    = div_q == DW'(CLK_DIV - 1);
        state_d = state_q;
        bit_d   = bit_q;
        data_d  = data_q;
        div_d   = last ? '0 : div_q + DW'(1);
        case (state_q)
            ST_IDLE: begin
                div_d   = '0;
                bit_d   = '0;
                state_d = start ? ST_START : ST_IDLE;
                data_d  = start ? data : data_q;
            end
            ST_START: state_d = last ? ST_DATA : ST_START;
            ST_DATA: begin
                bit_d   = last ? bit_q + 3'd1 : bit_q;
                state_d = (last && bit_q == 3'd7) ? ST_STOP : ST_DATA;
            end
            default: state_d = last ? ST_IDLE : ST_STOP;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end
    assign txd        = state_q == ST_START ? 1'b0 : state_q == ST_DATA ? data_q[bit_q] : 1'b1;
    assign busy       = state_q != ST_IDLE;
    assign done_pulse = state_q == ST_STOP && last;
endmodule

// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED/7-seg/switch ports and UART at 0x4000_0000.
// The UART transmitter exists only when PERIPH_UART_EN is defined.
module peripheral_bus import periph_pkg::*; #(
    parameter int CLK_DIV = 5208
) (
    input  logic             clk,
    input  logic             reset,
    peripheral_bus_if.slave  bus,
    input  logic [7:0]       switch,
    output logic [7:0]       led,
    output logic [11:0]      digi,
    output logic             irqout,
    output logic             uart_txd
);
    logic [31:0] th_q, th_d, tl_q, tl_d, rd_mux;
    logic [2:0]  tcon_q, tcon_d, off;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic        sel, we, wr_tcon, ovf, unused_addr;
    assign unused_addr = ^bus.addr[1:0];
    assign sel = bus.addr[31:5] == PERIPH_BASE[31:5];
    assign off = bus.addr[4:2];
    assign we  = bus.wr && sel;
    always_comb begin
        wr_tcon   = we && off == REG_TCON;
        ovf       = tcon_q[TCON_EN] && &tl_q;
        th_d      = (we && off == REG_TH) ? bus.wdata : th_q;
        tl_d      = (we && off == REG_TL) ? bus.wdata : ovf ? th_q : tcon_q[TCON_EN] ? tl_q + 32'd1 : tl_q;
        tcon_d[1:0] = wr_tcon ? bus.wdata[1:0] : tcon_q[1:0];
        // an overflow landing on a TCON write still sets the status bit
        tcon_d[TCON_OV] = (wr_tcon ? bus.wdata[2] : tcon_q[TCON_OV]) | (ovf & tcon_q[TCON_IE]);
        led_d     = (we && off == REG_LED) ? bus.wdata[7:0] : led_q;
        digi_d    = (we && off == REG_DIGI) ? bus.wdata[11:0] : digi_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end
`ifdef PERIPH_UART_EN
    logic busy, done_pulse, done_q, done_d;
    uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk(clk), .reset(reset), .start(we && off == REG_UART_TXD && !busy),
        .data(bus.wdata[7:0]), .txd(uart_txd), .busy(busy), .done_pulse(done_pulse)
    );
    assign done_d = done_pulse | (done_q & !(we && off == REG_UART_CON));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= done_d;
    end
`else
    localparam int unused_clk_div = CLK_DIV;
    assign uart_txd = 1'b1;
`endif
    always_comb begin
        rd_mux = '0;
        case (off)
            REG_TH:       rd_mux = th_q;
            REG_TL:       rd_mux = tl_q;
            REG_TCON:     rd_mux = {29'd0, tcon_q};
            REG_LED:      rd_mux = {24'd0, led_q};
            REG_SWITCH:   rd_mux = {24'd0, switch};
            REG_DIGI:     rd_mux = {20'd0, digi_q};
`ifdef PERIPH_UART_EN
            REG_UART_CON: rd_mux = {30'd0, busy, done_q};
`endif
            default:      rd_mux = '0;
        endcase
        bus.rdata = (bus.rd && sel) ? rd_mux : '0;
    end
    assign led    = led_q;
    assign digi   = digi_q;
    assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_OV];
endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: scoreboard bench for peripheral_bus; UART section follows PERIPH_UART_EN
module tb_peripheral_bus;
    import periph_pkg::*;
    localparam int DIV = 4;
    localparam logic [31:0] B = 32'h4000_0000;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  switch_i = 8'h5C;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout, uart_txd;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    peripheral_bus_if bus();
    peripheral_bus #(.CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .bus(bus), .switch(switch_i),
        .led(led), .digi(digi), .irqout(irqout), .uart_txd(uart_txd)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic observe(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        check(tag, got, exp);
    endtask
    task automatic out_chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        exp_q.push_back(exp);
        observe(tag, got);
    endtask
    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr = 1'b1;
        bus.addr = a;
        bus.wdata = d;
        @(negedge clk);
        bus.wr = 1'b0;
    endtask
    task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.rd = 1'b1;
        bus.addr = a;
        #1;
        observe(tag, bus.rdata);
        bus.rd = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        logic [9:0] frame;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        out_chk("rst_txd", uart_txd, 1);
        out_chk("rst_irq", irqout, 0);
        out_chk("rst_led", led, 0);
        out_chk("rst_digi", digi, 0);
        reset = 1'b0;
        rd_reg("tcon_rst", B + 8, 0);
        rd_reg("tl_rst", B + 4, 0);
        wr_reg(B + 'h0C, 32'hFFFF_FFA5);
        wr_reg(B + 'h14, 32'h0000_F3F7);
        out_chk("led_out", led, 'hA5);
        out_chk("digi_out", digi, 'h3F7);
        rd_reg("led_rd", B + 'h0C, 'hA5);
        rd_reg("digi_rd", B + 'h14, 'h3F7);
        rd_reg("switch_rd", B + 'h10, 'h5C);
        exp_q.push_back(0);
        bus.addr = B + 'h0C;
        #1;
        observe("rd_idle", bus.rdata);
        wr_reg(32'h4000_002C, 0);
        wr_reg(32'h0000_000C, 0);
        out_chk("led_unmapped", led, 'hA5);
        rd_reg("unmapped_rd", 32'h4000_002C, 0);
        wr_reg(B + 0, 32'hFFFF_FFFC);
        wr_reg(B + 4, 32'hFFFF_FFFC);
        wr_reg(B + 8, 3);
        rd_reg("tl_hold", B + 4, 32'hFFFF_FFFC);
        @(negedge clk);
        rd_reg("tl_inc", B + 4, 32'hFFFF_FFFD);
        out_chk("irq_pre", irqout, 0);
        repeat (3) @(negedge clk);
        rd_reg("tl_reload", B + 4, 32'hFFFF_FFFC);
        out_chk("irq_set", irqout, 1);
        rd_reg("tcon_ov", B + 8, 7);
        wr_reg(B + 8, 3);
        out_chk("irq_clr", irqout, 0);
        rd_reg("tl_pre_coll", B + 4, 32'hFFFF_FFFE);
        wr_reg(B + 8, 3);
        rd_reg("tcon_coll", B + 8, 7);
        out_chk("irq_coll", irqout, 1);
        rd_reg("tl_coll", B + 4, 32'hFFFF_FFFC);
        wr_reg(B + 4, 'h10);
        rd_reg("tl_wr", B + 4, 'h10);
        @(negedge clk);
        rd_reg("tl_wr_inc", B + 4, 'h11);
        wr_reg(B + 8, 0);
        out_chk("irq_off", irqout, 0);
`ifdef PERIPH_UART_EN
        rd_reg("con_idle", B + 'h1C, 0);
        frame = {1'b1, 8'h55, 1'b0};
        wr_reg(B + 'h18, 'h55);
        for (int i = 0; i < 10 * DIV; i++) begin
            out_chk("txd_bit", uart_txd, frame[i / DIV]);
            if (i % 8 == 0) rd_reg("con_busy", B + 'h1C, 2);
            if (i == 10) begin
                bus.wr = 1'b1;
                bus.addr = B + 'h18;
                bus.wdata = 0;
            end else bus.wr = 1'b0;
            @(negedge clk);
        end
        bus.wr = 1'b0;
        out_chk("txd_idle", uart_txd, 1);
        rd_reg("con_done", B + 'h1C, 1);
        rd_reg("txd_reg_rd", B + 'h18, 0);
        wr_reg(B + 'h1C, 0);
        rd_reg("con_clr", B + 'h1C, 0);
        wr_reg(B + 'h18, 'hFF);
        repeat (2) @(negedge clk);
        out_chk("txd_start", uart_txd, 0);
        reset = 1'b1;
        #1;
        out_chk("txd_rst", uart_txd, 1);
        rd_reg("con_rst", B + 'h1C, 0);
        @(negedge clk);
        reset = 1'b0;
`else
        frame = '0;
        wr_reg(B + 'h18, 0);
        out_chk("txd_tied", uart_txd, 1);
        @(negedge clk);
        out_chk("txd_tied2", uart_txd, 1);
        wr_reg(B + 'h1C, 3);
        rd_reg("con_absent", B + 'h1C, 0);
        rd_reg("txd_reg_rd", B + 'h18, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
